// File: rtl/axi_light_slave_regs.sv
// rtl/axi_light_slave_regs.sv - AXI Light slave terminating a link in a bank of byte-strobed registers
module axi_light_slave_regs #(
    parameter int                        AXI_DATA_WIDTH  = 32,
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter int                        AXI_WSTRB_WIDTH = 4,
    parameter int                        NUM_REGS        = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [AXI_ADDR_WIDTH-1:0]  awaddr,
    input  logic [2:0]                 awprot,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [AXI_DATA_WIDTH-1:0]  wdata,
    input  logic [AXI_WSTRB_WIDTH-1:0] wstrb,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [AXI_ADDR_WIDTH-1:0]  araddr,
    input  logic [2:0]                 arprot,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [AXI_DATA_WIDTH-1:0]  rdata,
    output logic [1:0]                 rresp
);
    localparam int LSB  = $clog2(AXI_WSTRB_WIDTH);
    localparam int IDXW = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH-1:0] offset;
        offset = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((offset >> (LSB + IDXW)) == '0);
    endfunction

    function automatic logic [IDXW-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH-1:0] offset;
        offset = a - BASE_ADDR;
        return IDXW'(offset >> LSB);
    endfunction

    logic unused_prot;
    assign unused_prot = ^{awprot, arprot};

    logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

    w_state_t                   w_state, w_state_nxt;
    logic                       aw_flag, w_flag, aw_flag_nxt, w_flag_nxt;
    logic                       awready_nxt, wready_nxt, bvalid_nxt;
    logic [AXI_ADDR_WIDTH-1:0]  aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0]  w_data_q;
    logic [AXI_WSTRB_WIDTH-1:0] w_strb_q;
    logic                       aw_hs, w_hs, commit;
    logic [AXI_ADDR_WIDTH-1:0]  wr_addr;
    logic [AXI_DATA_WIDTH-1:0]  wr_data;
    logic [AXI_WSTRB_WIDTH-1:0] wr_strb;

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    // A channel captured this cycle bypasses its holding register so commit needs no extra cycle.
    assign wr_addr = aw_flag ? aw_addr_q : awaddr;
    assign wr_data = w_flag ? w_data_q : wdata;
    assign wr_strb = w_flag ? w_strb_q : wstrb;
    assign commit  = (w_state == W_IDLE) & (aw_flag | aw_hs) & (w_flag | w_hs);

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE: if (commit) w_state_nxt = W_RESP;
            W_RESP: if (bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        aw_flag_nxt = (aw_flag | aw_hs) & ~commit;
        w_flag_nxt  = (w_flag | w_hs) & ~commit;
        awready_nxt = (w_state_nxt == W_IDLE) & ~aw_flag_nxt;
        wready_nxt  = (w_state_nxt == W_IDLE) & ~w_flag_nxt;
        bvalid_nxt  = (w_state_nxt == W_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state   <= W_IDLE;
            aw_flag   <= 1'b0;
            w_flag    <= 1'b0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            w_state <= w_state_nxt;
            aw_flag <= aw_flag_nxt;
            w_flag  <= w_flag_nxt;
            awready <= awready_nxt;
            wready  <= wready_nxt;
            bvalid  <= bvalid_nxt;
            if (aw_hs) aw_addr_q <= awaddr;
            if (w_hs) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit) begin
                bresp <= addr_ok(wr_addr) ? RESP_OKAY : RESP_SLVERR;
                if (addr_ok(wr_addr)) begin
                    for (int i = 0; i < AXI_WSTRB_WIDTH; i++) begin
                        if (wr_strb[i]) regs[addr_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

    r_state_t r_state, r_state_nxt;
    logic     arready_nxt, rvalid_nxt, ar_hs;

    assign ar_hs = arvalid & arready;

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE: if (ar_hs) r_state_nxt = R_RESP;
            R_RESP: if (rready) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        arready_nxt = (r_state_nxt == R_IDLE);
        rvalid_nxt  = (r_state_nxt == R_RESP);
    end

    // Sampling regs here sees the pre-write value when a write commits on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            r_state <= r_state_nxt;
            arready <= arready_nxt;
            rvalid  <= rvalid_nxt;
            if (ar_hs) begin
                rdata <= addr_ok(araddr) ? regs[addr_idx(araddr)] : '0;
                rresp <= addr_ok(araddr) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end
endmodule

// File: tb/tb_axi_light_slave_regs.sv
// tb/tb_axi_light_slave_regs.sv - self-checking bench for axi_light_slave_regs
module tb_axi_light_slave_regs;
    localparam int          NR   = 16;
    localparam logic [31:0] BASE = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    logic [31:0] mdl [NR];
    int          checks   = 0;
    int          failures = 0;

    axi_light_slave_regs #(
        .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .AXI_WSTRB_WIDTH(4),
        .NUM_REGS(NR), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ok(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < NR);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_d, input int w_d, input int hold);
        logic [1:0] er;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        er = m_ok(addr) ? 2'b00 : 2'b10;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && cyc >= aw_d;
            wvalid  = !w_done && cyc >= w_d;
            aw_hs   = awvalid && awready;
            w_hs    = wvalid && wready;
            tick();
            cyc++;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            if (w_done && !aw_done) chk("wready_drop", wready, 0);
            if (aw_done && !w_done) chk("awready_drop", awready, 0);
        end
        awvalid = 0; wvalid = 0;
        chk("write_handshakes", aw_done && w_done, 1);
        chk("b_valid_latency", bvalid, 1);
        chk("b_resp", bresp, er);
        if (m_ok(addr)) begin
            for (int i = 0; i < 4; i++) if (strb[i]) mdl[m_idx(addr)][8*i +: 8] = data[8*i +: 8];
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("b_hold_valid", bvalid, 1);
            chk("b_hold_resp", bresp, er);
            chk("b_hold_awready", awready, 0);
            chk("b_hold_wready", wready, 0);
        end
        bready = 1;
        tick();
        bready = 0;
        chk("b_done", bvalid, 0);
        chk("aw_rearm", awready, 1);
        chk("w_rearm", wready, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold);
        logic [31:0] ed;
        logic [1:0]  er;
        bit hs = 0;
        int cyc = 0;
        ed = m_ok(addr) ? mdl[m_idx(addr)] : 32'h0;
        er = m_ok(addr) ? 2'b00 : 2'b10;
        araddr = addr;
        arvalid = 1;
        while (!hs && cyc < 20) begin
            hs = arready;
            tick();
            cyc++;
        end
        arvalid = 0;
        chk("ar_handshake", hs, 1);
        chk("r_valid_latency", rvalid, 1);
        chk("r_data", rdata, ed);
        chk("r_resp", rresp, er);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("r_hold_valid", rvalid, 1);
            chk("r_hold_data", rdata, ed);
            chk("r_hold_resp", rresp, er);
            chk("r_hold_arready", arready, 0);
        end
        rready = 1;
        tick();
        rready = 0;
        chk("r_done", rvalid, 0);
        chk("ar_rearm", arready, 1);
    endtask

    task automatic read_all();
        for (int i = 0; i < NR; i++) do_read(BASE + 32'(4 * i), 0);
    endtask

    initial begin
        logic [31:0] a;
        reset = 1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 3'b010; arprot = 3'b001;
        for (int i = 0; i < NR; i++) mdl[i] = 0;
        tick();
        tick();
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        reset = 0;
        tick();
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 1);
        chk("post_rst_arready", arready, 1);

        do_write(BASE + 32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(BASE + 32'h8, 0);

        do_write(BASE + 32'h4, 32'h11223344, 4'hF, 3, 0, 0);
        do_read(BASE + 32'h4, 0);
        do_write(BASE + 32'hC, 32'h55667788, 4'hF, 0, 2, 0);
        do_read(BASE + 32'hC, 0);

        do_write(BASE + 32'h14, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        do_write(BASE + 32'h14, 32'h00000000, 4'h5, 0, 0, 0);
        do_read(BASE + 32'h14, 0);
        do_read(BASE + 32'h17, 0);

        do_write(BASE + 32'(NR * 4), 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        read_all();
        do_read(BASE + 32'(NR * 4), 0);
        do_write(BASE - 32'h4, 32'h12345678, 4'hF, 1, 0, 0);
        do_read(BASE - 32'h4, 0);

        do_write(BASE + 32'h18, 32'hCAFEF00D, 4'h3, 0, 0, 5);
        do_read(BASE + 32'h18, 5);

        do_write(BASE + 32'h8, 32'h1, 4'hF, 0, 0, 0);
        awaddr = BASE + 32'h8; wdata = 32'h2; wstrb = 4'hF; araddr = BASE + 32'h8;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("coll_bvalid", bvalid, 1);
        chk("coll_rvalid", rvalid, 1);
        chk("coll_rdata_old", rdata, mdl[2]);
        mdl[2] = 32'h2;
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        do_read(BASE + 32'h8, 0);

        for (int n = 0; n < 150; n++) begin
            a = BASE - 32'h8 + 32'($urandom_range(0, NR * 4 + 15));
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2));
        end

        awaddr = BASE + 32'hC; wdata = 32'h99; wstrb = 4'hF; araddr = BASE + 32'h4;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("pre_rst_bvalid", bvalid, 1);
        chk("pre_rst_rvalid", rvalid, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_rvalid", rvalid, 0);
        tick();
        chk("mid_rst_awready", awready, 1);
        chk("mid_rst_wready", wready, 1);
        chk("mid_rst_arready", arready, 1);
        chk("mid_rst_no_bvalid", bvalid, 0);
        for (int i = 0; i < NR; i++) mdl[i] = 0;
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_light_slave_regs.md
# axi_light_slave_regs

AXI Light slave that terminates one `if_axi_light` link in a bank of `NUM_REGS` memory-mapped data-width registers. It sits behind the interconnect as the responder for any AXI Light master in the SoC, such as core peripherals or debug/control registers. It accepts write address and write data independently and in any order, applies byte strobes, and returns OKAY or SLVERR responses. Read and write channels are serviced by two independent state machines.

## Interface
Parameters:
- `AXI_DATA_WIDTH`, default 32: data bus width; also the register width.
- `AXI_ADDR_WIDTH`, default 32: address bus width.
- `AXI_WSTRB_WIDTH`, default 4: strobe width, equal to `AXI_DATA_WIDTH/8`.
- `NUM_REGS`, default 16: number of registers; must be a power of two and at least 2.
- `BASE_ADDR`, default 0: byte address of register 0; must be aligned to `NUM_REGS*AXI_WSTRB_WIDTH`.

Ports (single clock domain; reset is synchronous and active-high):
- `clk` input 1: clock; all logic acts on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `awvalid` input 1, `awready` output 1, `awaddr` input `AXI_ADDR_WIDTH`, `awprot` input 3: write address channel.
- `wvalid` input 1, `wready` output 1, `wdata` input `AXI_DATA_WIDTH`, `wstrb` input `AXI_WSTRB_WIDTH`: write data channel.
- `bvalid` output 1, `bready` input 1, `bresp` output 2: write response channel.
- `arvalid` input 1, `arready` output 1, `araddr` input `AXI_ADDR_WIDTH`, `arprot` input 3: read address channel.
- `rvalid` output 1, `rready` input 1, `rdata` output `AXI_DATA_WIDTH`, `rresp` output 2: read response channel.

## Operation
- **Address decode**
  - offset = addr − `BASE_ADDR`.
  - index = offset >> log2(`AXI_WSTRB_WIDTH`). The low offset bits are ignored, so misaligned addresses are treated as aligned.
  - In range: addr ≥ `BASE_ADDR` and index < `NUM_REGS`. Anything else is out of range.
  - `awprot` and `arprot` are ignored.
- **Write FSM, W_IDLE ↔ W_RESP**
  - W_IDLE:
    - `awready` = 1 until the address is captured; `wready` = 1 until the data is captured.
    - Each handshake (valid & ready) latches its channel into a holding register and sets a collected flag.
  - Transition to W_RESP:
    - Occurs on the edge where both flags are set, counting handshakes in that same cycle.
    - Covers AW before W, W before AW, or both in the same cycle.
    - On that edge:
      - In range: every byte lane with `wstrb[i]`=1 is written; lanes with 0 keep their value; `bresp` = 2'b00.
      - Out of range: no register changes; `bresp` = 2'b10 (SLVERR).
      - Both flags clear.
  - W_RESP: `bvalid` = 1; `awready` = `wready` = 0; `bresp` is stable.
  - Transition to W_IDLE on `bready` = 1.
- **Read FSM, R_IDLE ↔ R_RESP**
  - R_IDLE: `arready` = 1.
  - Transition to R_RESP on `arvalid`:
    - `rdata` is registered: register contents if in range, else 0.
    - `rresp` = 2'b00 if in range, else 2'b10.
  - R_RESP: `rvalid` = 1, `arready` = 0, `rdata` and `rresp` stable.
  - Transition to R_IDLE on `rready` = 1.
- **Read/write collision:** if a read is captured on the same edge that a write commits to the same register, the read returns the pre-write value.
- **Channel independence:** the read and write FSMs never stall each other.

## Timing
- **Outputs are registered.** Values while `reset` is high at a clock edge:
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid` = 0.
  - `bresp`, `rresp`, `rdata` = 0.
  - All registers and holding registers = 0; both FSMs go to IDLE; collected flags clear.
- **After reset deasserts**, `awready`, `wready` and `arready` read 1 in the first cycle.
- **Write latency:** last of the AW/W handshakes in cycle N gives `bvalid` = 1 in cycle N+1, and the register shows the new value from cycle N+1.
- **Write re-arm:** B handshake in cycle M gives `awready` = `wready` = 1 in cycle M+1. Peak write throughput is one transaction per 2 cycles.
- **Read latency:** AR handshake in cycle N gives `rvalid` = 1 in cycle N+1. R handshake in cycle M gives `arready` = 1 in cycle M+1. Peak read throughput is one per 2 cycles.
- **Held responses:** `bvalid` and `rvalid` are never deasserted before `bready` and `rready` respectively, even if the master stalls indefinitely.
- **Reset mid-transaction:** any outstanding transaction is dropped. No response is issued afterwards and all registers read 0.

## Test plan
- **Write then read:** AW/W same cycle, addr `BASE_ADDR`+0x8, data 0xDEADBEEF, strb 0xF.
  - `bvalid` next cycle, `bresp` 00.
  - Read of `BASE_ADDR`+0x8 → `rvalid` one cycle after AR, `rdata` 0xDEADBEEF, `rresp` 00.
- **Out-of-order channels:** W (data 0x11223344) 3 cycles before AW (addr +0x4).
  - `wready` drops after the W handshake.
  - `bvalid` exactly one cycle after the AW handshake.
  - Readback 0x11223344.
- **Byte strobes:** register holds 0xAABBCCDD; write 0x00000000 with strb 0x5 → readback 0xAA00CC00.
- **Out of range:** write to `BASE_ADDR` + `NUM_REGS`*4 → `bresp` 10, and all registers are unchanged. Read of the same address → `rdata` 0, `rresp` 10.
- **Backpressure and collision:**
  - Hold `bready`/`rready` low for 5 cycles: `bvalid`/`rvalid` and the response fields stay stable, and `awready`/`arready` stay 0.
  - Same-edge read and write to register 2 (old value 0x1, new 0x2) → read returns 0x1; a following read returns 0x2.
- **Reset:** assert `reset` for 1 cycle while in W_RESP and R_RESP.
  - Next cycle: `bvalid` = `rvalid` = 0.
  - Following cycle: `awready` = `wready` = `arready` = 1.
  - All registers read 0.
